// File: rtl/beta_irq_ctrl.sv
// beta_irq_ctrl: edge-triggered, maskable, priority-encoded interrupt controller feeding
// the control unit's IRQ input. An acknowledged request blocks further requests until
// software writes EOI.
// Optional macro BETA_IRQ_SYNC_EN: adds a 2-flop synchronizer on SRC before edge detection.
module beta_irq_ctrl #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned IDW  = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [NSRC-1:0] SRC,
    input  logic            SUPER,
    output logic            IRQ,
    output logic [IDW-1:0]  IRQ_ID,
    input  logic            IRQ_ACK,
    input  logic            CSR_WE,
    input  logic [1:0]      CSR_ADDR,
    input  logic [NSRC-1:0] CSR_WDATA,
    output logic [NSRC-1:0] CSR_RDATA
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e              state_q, state_d;
    logic [NSRC-1:0]     src_in;
    logic [NSRC-1:0]     src_q;
    logic [NSRC-1:0]     mask_q;
    logic [NSRC-1:0]     pend_q, pend_d;
    logic [IDW-1:0]      active_q;
    logic [IDW-1:0]      irq_id_q;
    logic [IDW-1:0]      enc_id;
    logic [NSRC-1:0]     rdata_q, rdata_d;
    logic [NSRC-1:0]     elig;
    logic [NSRC-1:0]     edge_set;
    logic [NSRC-1:0]     ack_clr;
    logic [NSRC-1:0]     w1c_clr;
    logic [NSRC+IDW-1:0] active_wide;
    logic                ack_take;
    logic                mask_wr;
    logic                eoi_wr;

`ifdef BETA_IRQ_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous peripheral lines
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= SRC;
            sync2_q <= sync1_q;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = SRC;
`endif

    assign mask_wr  = CSR_WE && (CSR_ADDR == 2'd0);
    assign w1c_clr  = (CSR_WE && (CSR_ADDR == 2'd1)) ? CSR_WDATA : '0;
    assign eoi_wr   = CSR_WE && (CSR_ADDR == 2'd3);
    assign edge_set = src_in & ~src_q;
    assign elig     = pend_q & mask_q;
    // Shift yields zero for an ID outside the source range
    assign ack_clr  = ack_take ? (NSRC'(1) << irq_id_q) : '0;
    assign IRQ      = (state_q == StReq) && !SUPER;
    assign IRQ_ID   = irq_id_q;
    assign CSR_RDATA   = rdata_q;
    assign active_wide = {{NSRC{1'b0}}, active_q};

    // Lowest index wins; zero when nothing is eligible
    always_comb begin
        enc_id = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (elig[i]) enc_id = IDW'(i);
        end
    end

    // Pending update: clears first, a new edge on the same bit wins
    always_comb begin
        pend_d = (pend_q & ~w1c_clr & ~ack_clr) | edge_set;
    end

    // FSM next state; an ACK seen with IRQ high is always honoured
    always_comb begin
        state_d  = state_q;
        ack_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (elig != '0) state_d = StReq;
            end
            StReq: begin
                if (IRQ_ACK && IRQ) begin
                    ack_take = 1'b1;
                    state_d  = StService;
                end else if (elig == '0) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (eoi_wr) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // CSR read mux; ACTIVE is zero-extended, EOI reads as zero
    always_comb begin
        rdata_d = '0;
        case (CSR_ADDR)
            2'd0:    rdata_d = mask_q;
            2'd1:    rdata_d = pend_q;
            2'd2:    rdata_d = active_wide[NSRC-1:0];
            default: rdata_d = '0;
        endcase
    end

    // State, pending, mask, ID and read-data registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            src_q    <= '0;
            mask_q   <= '0;
            pend_q   <= '0;
            active_q <= '0;
            irq_id_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_in;
            pend_q   <= pend_d;
            irq_id_q <= enc_id;
            rdata_q  <= rdata_d;
            if (mask_wr)  mask_q   <= CSR_WDATA;
            if (ack_take) active_q <= irq_id_q;
        end
    end

endmodule

// File: tb/tb_beta_irq_ctrl.sv
// Self-checking bench for beta_irq_ctrl (NSRC=8, IDW=4). Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT output is observed.
module tb_beta_irq_ctrl;

`ifdef BETA_IRQ_SYNC_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 2;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] src;
    logic       super_m;
    logic       irq;
    logic [3:0] irq_id;
    logic       irq_ack;
    logic       csr_we;
    logic [1:0] csr_addr;
    logic [7:0] csr_wdata;
    logic [7:0] csr_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] obs;

    beta_irq_ctrl #(.NSRC(8), .IDW(4)) dut (
        .CLK(clk), .RESET_N(rst_n), .SRC(src), .SUPER(super_m), .IRQ(irq), .IRQ_ID(irq_id),
        .IRQ_ACK(irq_ack), .CSR_WE(csr_we), .CSR_ADDR(csr_addr), .CSR_WDATA(csr_wdata),
        .CSR_RDATA(csr_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [7:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        step();
        csr_we = 1'b0; csr_wdata = 8'h00;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_addr = a;
        step();
        d = {24'h0, csr_rdata};
    endtask

    task automatic pulse(input logic [7:0] s);
        src = s;
        step();
        src = 8'h00;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src = 0; super_m = 0; irq_ack = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
        step(); step();
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL rst_irq: got %0h want %0h", obs, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {28'h0, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL rst_id: got %0h want %0h", obs, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {24'h0, csr_rdata}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL rst_rdata: got %0h want %0h", obs, exp); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mask_gate();
        pulse(8'h08);
        repeat (Lat) step();
        exp_q.push_back(32'h08);
        csr_rd(2'd1, obs);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin failures++; $display("FAIL mask_pend: got %0h want %0h", obs, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL masked_irq: got %0h want %0h", obs, exp); end
        csr_wr(2'd0, 8'h08);
        step();
        exp_q.push_back(32'h1); exp_q.push_back(32'h3);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL unmask_irq: got %0h want %0h", obs, exp); end
        exp = exp_q.pop_front(); obs = {28'h0, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL unmask_id: got %0h want %0h", obs, exp); end
        ack();
        exp_q.push_back(32'h3);
        csr_rd(2'd2, obs);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin failures++; $display("FAIL active3: got %0h want %0h", obs, exp); end
        csr_wr(2'd3, 8'h00);
    endtask

    task automatic test_priority();
        csr_wr(2'd0, 8'hFF);
        src = 8'h24;
        step();
        src = 8'h00;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL prio_early: got %0h want %0h", obs, exp); end
        repeat (Lat - 1) step();
        exp_q.push_back(32'h1); exp_q.push_back(32'h2);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL prio_irq: got %0h want %0h", obs, exp); end
        exp = exp_q.pop_front(); obs = {28'h0, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL prio_id: got %0h want %0h", obs, exp); end
        ack();
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL svc_irq: got %0h want %0h", obs, exp); end
        exp_q.push_back(32'h20);
        csr_rd(2'd1, obs);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin failures++; $display("FAIL ack_pend: got %0h want %0h", obs, exp); end
        exp_q.push_back(32'h2);
        csr_rd(2'd2, obs);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin failures++; $display("FAIL active2: got %0h want %0h", obs, exp); end
        csr_wr(2'd3, 8'h5A);
        step();
        exp_q.push_back(32'h1); exp_q.push_back(32'h5);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL eoi_irq: got %0h want %0h", obs, exp); end
        exp = exp_q.pop_front(); obs = {28'h0, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL eoi_id: got %0h want %0h", obs, exp); end
        ack();
        csr_wr(2'd3, 8'h00);
    endtask

    task automatic test_super();
        pulse(8'h40);
        repeat (Lat - 1) step();
        super_m = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL super_irq: got %0h want %0h", obs, exp); end
        ack();
        super_m = 1'b0;
        #1;
        exp_q.push_back(32'h1); exp_q.push_back(32'h6);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL super_rel: got %0h want %0h", obs, exp); end
        exp = exp_q.pop_front(); obs = {28'h0, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL super_id: got %0h want %0h", obs, exp); end
        csr_wr(2'd3, 8'h00);
        step();
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL eoi_in_req: got %0h want %0h", obs, exp); end
        ack();
        csr_wr(2'd3, 8'h00);
    endtask

    task automatic test_w1c();
        pulse(8'h02);
        repeat (Lat - 1) step();
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); obs = {28'h0, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL w1c_id: got %0h want %0h", obs, exp); end
        csr_wr(2'd1, 8'h02);
        step();
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL w1c_irq: got %0h want %0h", obs, exp); end
        exp_q.push_back(32'h0);
        csr_rd(2'd1, obs);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin failures++; $display("FAIL w1c_pend: got %0h want %0h", obs, exp); end
        pulse(8'h02);
        repeat (Lat - 1) step();
        // New edge reaches the pending register in the same cycle as the W1C
        src = 8'h02;
        repeat (Lat - 2) step();
        csr_wr(2'd1, 8'h02);
        src = 8'h00;
        step();
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL race_irq: got %0h want %0h", obs, exp); end
        exp_q.push_back(32'h02);
        csr_rd(2'd1, obs);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin failures++; $display("FAIL race_pend: got %0h want %0h", obs, exp); end
        ack();
        csr_wr(2'd3, 8'h00);
    endtask

    task automatic test_level();
        src = 8'h10;
        repeat (Lat) step();
        exp_q.push_back(32'h4);
        exp = exp_q.pop_front(); obs = {28'h0, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL level_id: got %0h want %0h", obs, exp); end
        ack();
        csr_wr(2'd3, 8'h00);
        repeat (3) step();
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {31'h0, irq}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL level_retrig: got %0h want %0h", obs, exp); end
        src = 8'h00;
        step();
    endtask

    task automatic test_reset_mid_service();
        pulse(8'h80);
        repeat (Lat - 1) step();
        exp_q.push_back(32'h7);
        exp = exp_q.pop_front(); obs = {28'h0, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL id7: got %0h want %0h", obs, exp); end
        ack();
        exp_q.push_back(32'h7);
        csr_rd(2'd2, obs);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin failures++; $display("FAIL active7: got %0h want %0h", obs, exp); end
        src = 8'h01;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {27'h0, irq, irq_id}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL arst_irq: got %0h want %0h", obs, exp); end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); obs = {24'h0, csr_rdata}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL arst_rdata: got %0h want %0h", obs, exp); end
        step(); step();
        csr_addr = 2'd1;
        rst_n = 1'b1;
        // Pending sets on the first edge after release; read data lags by one edge
        repeat (Lat) step();
        exp_q.push_back(32'h01);
        exp = exp_q.pop_front(); obs = {24'h0, csr_rdata}; checks++;
        if (obs !== exp) begin failures++; $display("FAIL rel_pend: got %0h want %0h", obs, exp); end
        src = 8'h00;
        step();
    endtask

    initial begin
        test_reset();
        test_mask_gate();
        test_priority();
        test_super();
        test_w1c();
        test_level();
        test_reset_mid_service();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
